// File: rtl/fetch_unit_pkg.sv
// Shared widths, reset constants and fetch FSM encodings, plus the packed buffer entry type.
// The text macros sit ahead of the package so every later file in the build sees them.
`ifndef FETCH_DEFINES_DONE
`define FETCH_DEFINES_DONE
`define DataWidth  32
`define ZeroWord   32'h0000_0000
`define FETCH_IDLE 2'b00
`define FETCH_REQ  2'b01
`define FETCH_WAIT 2'b10
`define FETCH_DROP 2'b11
`endif

package fetch_unit_pkg;

    localparam int              DW        = `DataWidth;
    localparam logic [DW-1:0]   ZERO_WORD = `ZeroWord;

    typedef enum logic [1:0] {
        ST_IDLE = `FETCH_IDLE,
        ST_REQ  = `FETCH_REQ,
        ST_WAIT = `FETCH_WAIT,
        ST_DROP = `FETCH_DROP
    } fetch_state_t;

    typedef struct packed {
        logic [DW-1:0] pc;
        logic [DW-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order buffer of {pc, inst}; the head entry is read straight from storage registers.
// Zero-latency visibility after the push edge; clear wins over push/pop, pop on empty is ignored.
module fetch_fifo
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  fetch_entry_t i_push_dat,
    input  logic         i_pop,
    input  logic         i_clear,
    output fetch_entry_t o_head_dat,
    output logic         o_full,
    output logic         o_empty,
    output logic [1:0]   o_count
);

    fetch_entry_t r_mem [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign w_pop  = i_pop && (r_count != 2'd0);
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_clear) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_full     = (r_count == 2'd2);
    assign o_empty    = (r_count == 2'd0);
    assign o_count    = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, 2-entry buffer to decode; grant N -> id_valid N+2.
// Stops requesting when buffer + in-flight reach 2; flush drops everything. FETCH_PERF_EN adds fetch_stall_cnt.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [`DataWidth-1:0] pc_in,
    output logic                  pc_en,
    input  logic                  flush,
    output logic                  imem_req,
    output logic [`DataWidth-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [`DataWidth-1:0] imem_rdata,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [`DataWidth-1:0] id_inst,
    output logic [`DataWidth-1:0] id_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           fetch_stall_cnt
`endif
);

    fetch_state_t  r_state;
    fetch_state_t  w_state_nxt;
    logic [DW-1:0] r_pc_q;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [1:0]    w_count;
    logic [1:0]    w_count_after_push;
    fetch_entry_t  w_push_dat;
    fetch_entry_t  w_head;

    assign w_pop              = id_valid && id_ready && !flush;
    assign w_count_after_push = w_pop ? w_count : (w_count + 2'd1);
    assign w_push_dat         = '{pc: r_pc_q, inst: imem_rdata};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc_q  <= ZERO_WORD;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_REQ) && imem_gnt && !flush) begin
                r_pc_q <= pc_in;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        imem_req    = 1'b0;
        pc_en       = flush;
        case (r_state)
            ST_IDLE: begin
                if (!flush && !w_full) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                imem_req = !flush;
                if (flush) begin
                    w_state_nxt = ST_IDLE;
                end else if (imem_gnt) begin
                    pc_en       = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A flush with no data yet must still swallow the pending response.
                if (flush) begin
                    w_state_nxt = imem_rvalid ? ST_IDLE : ST_DROP;
                end else if (imem_rvalid) begin
                    w_push      = 1'b1;
                    w_state_nxt = (w_count_after_push < 2'd2) ? ST_REQ : ST_IDLE;
                end
            end
            ST_DROP: begin
                if (imem_rvalid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    fetch_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .i_clear    (flush),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

    assign imem_addr = pc_in;
    assign id_valid  = !w_empty;
    assign id_inst   = w_head.inst;
    assign id_pc     = w_head.pc;

`ifdef FETCH_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else if (id_ready && !id_valid && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign fetch_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: models the PC register and a one-outstanding instruction memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in;
    logic        pc_en;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_stall_cnt;
`endif

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .pc_en       (pc_en),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_inst     (id_inst),
        .id_pc       (id_pc)
`ifdef FETCH_PERF_EN
        ,
        .fetch_stall_cnt (fetch_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          n_pop = 0;
    int          cyc = 0;
    int          first_valid_cyc = -1;
    logic [31:0] popped_pc[$];
    logic [31:0] pc_reg = 32'h0;
    logic [31:0] redirect = 32'h0;
    logic [31:0] slow_addr = 32'hFFFF_FFFF;
    bit          gnt_en = 1'b0;
    bit          ready_en = 1'b0;
    bit          flush_next = 1'b0;
    bit          mem_busy = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    int          mem_cnt = 0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive at the falling edge, observe 1 ns later, advance models for the next edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        cyc++;
        pc_in      = pc_reg;
        flush      = flush_next;
        flush_next = 1'b0;
        imem_gnt   = gnt_en;
        id_ready   = ready_en;
        if (mem_busy && mem_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memword(mem_addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        #1;
        if (imem_req) chk("imem_addr", imem_addr, pc_reg);
        if (flush) begin
            chk("req_in_flush", 32'(imem_req), 32'd0);
            chk("pc_en_flush", 32'(pc_en), 32'd1);
            exp_q.delete();
        end else if (id_valid && id_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_depth", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("id_pc", id_pc, e.pc);
                chk("id_inst", id_inst, e.inst);
                n_pop++;
                popped_pc.push_back(id_pc);
            end
        end
        if (id_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (imem_rvalid) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (imem_req && imem_gnt) begin
            chk("one_outstanding", 32'(mem_busy), 32'd0);
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_cnt  = (imem_addr == slow_addr) ? 1 : 0;
            exp_q.push_back('{pc: pc_reg, inst: memword(pc_reg)});
        end
        if (pc_en) pc_reg = flush ? redirect : pc_reg + 32'd4;
    endtask

    task automatic do_reset(input bit check);
        @(negedge clk);
        rst         = 1'b1;
        flush       = 1'b0;
        flush_next  = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        id_ready    = ready_en;
        pc_reg      = 32'h0;
        pc_in       = 32'h0;
        mem_busy    = 1'b0;
        exp_q.delete();
        #1;
        if (check) begin
            chk("rst_id_valid", 32'(id_valid), 32'd0);
            chk("rst_imem_req", 32'(imem_req), 32'd0);
            chk("rst_pc_en", 32'(pc_en), 32'd0);
            chk("rst_id_inst", id_inst, 32'h0);
            chk("rst_id_pc", id_pc, 32'h0);
        end
        @(negedge clk);
        @(negedge clk);
        rst             = 1'b0;
        cyc             = 0;
        first_valid_cyc = -1;
        n_pop           = 0;
        popped_pc.delete();
        #1;
        chk("req_after_rst", 32'(imem_req), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          p0;
        logic [31:0] hold_pc;
        logic [31:0] addr0;

        // Streaming with an always-granting, single-cycle memory.
        ready_en = 1'b1;
        gnt_en   = 1'b1;
        do_reset(1'b1);
        repeat (12) cycle();
        chk("first_valid_cyc", 32'(first_valid_cyc), 32'd3);
        chk("stream_pops", 32'(n_pop), 32'd5);
        if (popped_pc.size() >= 3) begin
            chk("stream_pc0", popped_pc[0], 32'h0);
            chk("stream_pc1", popped_pc[1], 32'h4);
            chk("stream_pc2", popped_pc[2], 32'h8);
        end else begin
            chk("stream_count", 32'(popped_pc.size()), 32'd3);
        end

        // Backpressure: decode stalls, buffer fills to two and fetching stops.
        ready_en = 1'b0;
        repeat (6) cycle();
        chk("bp_depth", 32'(exp_q.size()), 32'd2);
        hold_pc = (exp_q.size() > 0) ? exp_q[0].pc : 32'hFFFF_FFFF;
        repeat (4) begin
            cycle();
            chk("bp_req", 32'(imem_req), 32'd0);
            chk("bp_pc_en", 32'(pc_en), 32'd0);
            chk("bp_valid", 32'(id_valid), 32'd1);
            chk("bp_id_pc", id_pc, hold_pc);
            chk("bp_id_inst", id_inst, memword(hold_pc));
        end
        ready_en = 1'b1;
        p0 = n_pop;
        repeat (8) cycle();
        chk("bp_resumed", 32'((n_pop - p0) >= 3), 32'd1);

        // Flush while waiting on the slow response for 0x8.
        slow_addr = 32'h8;
        redirect  = 32'h100;
        do_reset(1'b0);
        for (int i = 0; i < 50 && !(mem_busy && mem_addr == 32'h8 && mem_cnt == 1); i++) cycle();
        chk("wait8_reached", 32'(mem_busy && mem_addr == 32'h8 && mem_cnt == 1), 32'd1);
        flush_next = 1'b1;
        cycle();
        cycle();
        chk("drop_req", 32'(imem_req), 32'd0);
        chk("drop_valid", 32'(id_valid), 32'd0);
        p0 = n_pop;
        for (int i = 0; i < 20 && n_pop == p0; i++) cycle();
        chk("redirect_pc", (n_pop > p0) ? popped_pc[p0] : 32'hFFFF_FFFF, 32'h100);

        // Flush coinciding with rvalid that would fill the buffer.
        slow_addr = 32'hFFFF_FFFF;
        redirect  = 32'h200;
        ready_en  = 1'b0;
        do_reset(1'b0);
        for (int i = 0; i < 50 && !(mem_busy && mem_cnt == 0 && exp_q.size() == 2); i++) cycle();
        chk("full_rvalid_reached", 32'(mem_busy && mem_cnt == 0 && exp_q.size() == 2), 32'd1);
        flush_next = 1'b1;
        cycle();
        chk("f_rvalid_seen", 32'(imem_rvalid), 32'd1);
        cycle();
        chk("f_valid_cleared", 32'(id_valid), 32'd0);
        chk("f_idle_req", 32'(imem_req), 32'd0);
        cycle();
        chk("f_restart_req", 32'(imem_req), 32'd1);
        ready_en = 1'b1;
        p0 = n_pop;
        for (int i = 0; i < 20 && n_pop == p0; i++) cycle();
        chk("f_first_pc", (n_pop > p0) ? popped_pc[p0] : 32'hFFFF_FFFF, 32'h200);

        // Grant withheld for five cycles while requesting.
        gnt_en = 1'b0;
        repeat (3) cycle();
        addr0 = pc_reg;
        repeat (5) begin
            cycle();
            chk("stall_req", 32'(imem_req), 32'd1);
            chk("stall_addr", imem_addr, addr0);
            chk("stall_pc_en", 32'(pc_en), 32'd0);
        end
        gnt_en = 1'b1;
        p0 = n_pop;
        repeat (8) cycle();
        chk("stall_resumed", 32'((n_pop - p0) >= 2), 32'd1);

`ifdef FETCH_PERF_EN
        // Starved decode: counter climbs, then holds once saturated.
        gnt_en   = 1'b0;
        ready_en = 1'b1;
        do_reset(1'b0);
        repeat (7) cycle();
        chk("stall_cnt_7", fetch_stall_cnt, 32'd7);
        force dut.r_stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_stall_cnt;
        repeat (3) cycle();
        chk("stall_cnt_sat", fetch_stall_cnt, 32'hFFFF_FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
